// File: rtl/byte_pair_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | byte_pair_pkg                                                          |
// | Shared types and constants for the byte-pair packer.                   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package byte_pair_pkg;

    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;

    // low occupies the upper half of the packed word, high the lower half
    typedef struct packed {
        logic [7:0] low;
        logic [7:0] high;
    } pair_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HALF = 1'b1
    } state_t;

    function automatic pair_t make_pair(input logic [7:0] lo, input logic [7:0] hi);
        pair_t p;
        p.low  = lo;
        p.high = hi;
        return p;
    endfunction

endpackage : byte_pair_pkg
`default_nettype wire

// File: rtl/byte_pair_out_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | byte_pair_out_reg                                                      |
// | Single-entry output holding register with load/drain handshake.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module byte_pair_out_reg
    import byte_pair_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  pair_t load_pair_i,
    input  logic  out_ready_i,
    output logic  out_valid_o,
    output pair_t out_pair_o,
    output logic  free_o,
    output logic  xfer_o
);

    logic  valid_q;
    logic  valid_d;
    pair_t pair_q;
    pair_t pair_d;

    assign xfer_o      = valid_q && out_ready_i;
    assign free_o      = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_pair_o  = pair_q;

    // A load on the same edge as a drain replaces the departing pair
    always_comb begin
        valid_d = valid_q;
        pair_d  = pair_q;
        if (load_i) begin
            valid_d = 1'b1;
            pair_d  = load_pair_i;
        end else if (xfer_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pair_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pair_q  <= pair_d;
        end
    end

endmodule : byte_pair_out_reg
`default_nettype wire

// File: rtl/byte_pair_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | byte_pair_packer                                                       |
// | Packs a byte stream into {low, high} pairs, with padded flush.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module byte_pair_packer
    import byte_pair_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    input  logic       flush,
    output logic       out_valid,
    output pair_t      out_pair,
    input  logic       out_ready,
    output logic       half_pending,
    output logic [7:0] pair_count
);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] low_q;
    logic [7:0] low_d;
    logic       flush_pend_q;
    logic       flush_pend_d;
    logic [7:0] count_q;

    logic       w_out_free;
    logic       w_out_xfer;
    logic       w_in_xfer;
    logic       w_flush_go;
    logic       w_load;
    pair_t      w_load_pair;

    assign w_in_xfer  = in_valid && in_ready;
    // Padding waits until the output register can take it; a real byte wins
    assign w_flush_go = (state_q == ST_HALF) && !w_in_xfer
                        && (flush_pend_q || flush) && w_out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            low_q        <= 8'h00;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            low_q        <= low_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        low_d        = low_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            ST_IDLE: begin
                flush_pend_d = 1'b0;
                if (w_in_xfer) begin
                    low_d   = in_byte;
                    state_d = ST_HALF;
                end
            end
            ST_HALF: begin
                if (w_in_xfer || w_flush_go) begin
                    state_d      = ST_IDLE;
                    flush_pend_d = 1'b0;
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                flush_pend_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        half_pending = (state_q == ST_HALF);
        in_ready     = (state_q == ST_IDLE) || w_out_free;
        w_load       = 1'b0;
        w_load_pair  = make_pair(low_q, in_byte);
        if (state_q == ST_HALF) begin
            if (w_in_xfer) begin
                w_load = 1'b1;
            end else if (w_flush_go) begin
                w_load      = 1'b1;
                w_load_pair = make_pair(low_q, PAD_BYTE);
            end
        end
    end

    byte_pair_out_reg u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (w_load),
        .load_pair_i (w_load_pair),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_pair_o  (out_pair),
        .free_o      (w_out_free),
        .xfer_o      (w_out_xfer)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'h00;
        end else if (w_out_xfer) begin
            count_q <= count_q + 8'h01;
        end
    end

    assign pair_count = count_q;

endmodule : byte_pair_packer
`default_nettype wire

// File: tb/tb_byte_pair_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_byte_pair_packer                                                    |
// | Directed self-checking bench with an expected-pair scoreboard.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_byte_pair_packer;
    import byte_pair_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    pair_t       out_pair;
    logic        out_ready;
    logic        half_pending;
    logic [7:0]  pair_count;

    int          n_checks;
    int          n_fail;
    logic [15:0] sb[$];
    logic [15:0] exp_pair;

    byte_pair_packer #(.PAD_BYTE(8'hEE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_pair     (out_pair),
        .out_ready    (out_ready),
        .half_pending (half_pending),
        .pair_count   (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 time unit after posedge, so the negedge sees what the next edge will
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed pair %h expected none", out_pair);
            end
            if (sb.size() != 0) begin
                exp_pair = sb.pop_front();
                n_checks++;
                assert (out_pair === exp_pair) else begin
                    n_fail++;
                    $error("FAIL sb_pair: observed %h expected %h", out_pair, exp_pair);
                end
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;

        step();
        step();
        chk("rst_in_ready",  {15'd0, in_ready},     16'd1);
        chk("rst_out_valid", {15'd0, out_valid},    16'd0);
        chk("rst_out_pair",  out_pair,              16'h0000);
        chk("rst_half",      {15'd0, half_pending}, 16'd0);
        chk("rst_count",     {8'd0, pair_count},    16'd0);
        rst_n = 1'b1;
        chk("post_rst_ready", {15'd0, in_ready},    16'd1);

        // stream
        out_ready = 1'b1;
        in_valid  = 1'b1; in_byte = 8'hA1;
        step();
        chk("stream_half", {15'd0, half_pending}, 16'd1);
        in_byte = 8'hB2; sb.push_back(16'hA1B2);
        step();
        in_valid = 1'b0;
        chk("stream_valid", {15'd0, out_valid}, 16'd1);
        chk("stream_pair",  out_pair,           16'hA1B2);
        step();
        chk("stream_valid_drop", {15'd0, out_valid}, 16'd0);
        chk("stream_count",      {8'd0, pair_count}, 16'd1);

        // backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1; in_byte = 8'h11;
        step();
        in_byte = 8'h22; sb.push_back(16'h1122);
        step();
        in_byte = 8'h33;
        chk("bp_ready_idle", {15'd0, in_ready}, 16'd1);
        step();
        in_byte = 8'h44; sb.push_back(16'h3344);
        chk("bp_stall", {15'd0, in_ready}, 16'd0);
        step();
        step();
        chk("bp_hold_valid", {15'd0, out_valid},    16'd1);
        chk("bp_hold_pair",  out_pair,              16'h1122);
        chk("bp_hold_half",  {15'd0, half_pending}, 16'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_back", {15'd0, in_ready}, 16'd1);
        step();
        in_valid = 1'b0;
        chk("bp_swap_valid", {15'd0, out_valid}, 16'd1);
        chk("bp_swap_pair",  out_pair,           16'h3344);
        step();
        chk("bp_drained", {15'd0, out_valid}, 16'd0);
        chk("bp_count",   {8'd0, pair_count}, 16'd3);

        // flush
        in_valid = 1'b1; in_byte = 8'h5C;
        step();
        in_valid = 1'b0; flush = 1'b1; sb.push_back(16'h5CEE);
        chk("fl_half_before", {15'd0, half_pending}, 16'd1);
        step();
        flush = 1'b0;
        chk("fl_half_after", {15'd0, half_pending}, 16'd0);
        chk("fl_pair",       out_pair,              16'h5CEE);
        step();
        chk("fl_count", {8'd0, pair_count}, 16'd4);

        // flush remembered while the output register is busy
        out_ready = 1'b0;
        in_valid  = 1'b1; in_byte = 8'h61;
        step();
        in_byte = 8'h62; sb.push_back(16'h6162);
        step();
        in_byte = 8'h63;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("flp_wait_half", {15'd0, half_pending}, 16'd1);
        chk("flp_wait_pair", out_pair,              16'h6162);
        sb.push_back(16'h63EE);
        out_ready = 1'b1;
        step();
        chk("flp_pair", out_pair,              16'h63EE);
        chk("flp_half", {15'd0, half_pending}, 16'd0);
        step();
        chk("flp_count", {8'd0, pair_count}, 16'd6);

        // byte beats flush
        in_valid = 1'b1; in_byte = 8'h01;
        step();
        in_byte = 8'h02; flush = 1'b1; sb.push_back(16'h0102);
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("prio_pair", out_pair, 16'h0102);
        step();
        step();
        chk("prio_no_pad",  {15'd0, out_valid},    16'd0);
        chk("prio_no_half", {15'd0, half_pending}, 16'd0);
        chk("prio_count",   {8'd0, pair_count},    16'd7);

        // counter wrap: 249 more pairs reach 256 in total
        for (int i = 0; i < 249; i++) begin
            in_valid = 1'b1; in_byte = i[7:0];
            step();
            in_byte = ~i[7:0]; sb.push_back({i[7:0], ~i[7:0]});
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_zero", {8'd0, pair_count}, 16'h0000);
        in_valid = 1'b1; in_byte = 8'hC3;
        step();
        in_byte = 8'h3C; sb.push_back(16'hC33C);
        step();
        in_valid = 1'b0;
        step();
        chk("wrap_one", {8'd0, pair_count}, 16'h0001);

        // reset mid-operation
        out_ready = 1'b0;
        in_valid  = 1'b1; in_byte = 8'h90;
        step();
        in_byte = 8'h91;
        step();
        in_byte = 8'h92;
        step();
        in_valid = 1'b0;
        chk("mid_half",  {15'd0, half_pending}, 16'd1);
        chk("mid_valid", {15'd0, out_valid},    16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {15'd0, out_valid},    16'd0);
        chk("mrst_pair",  out_pair,              16'h0000);
        chk("mrst_half",  {15'd0, half_pending}, 16'd0);
        chk("mrst_count", {8'd0, pair_count},    16'd0);
        chk("mrst_ready", {15'd0, in_ready},     16'd1);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1; in_byte = 8'h77;
        step();
        in_byte = 8'h88; sb.push_back(16'h7788);
        step();
        in_valid = 1'b0;
        chk("mrst_new_pair", out_pair, 16'h7788);
        step();
        chk("mrst_new_count", {8'd0, pair_count}, 16'd1);

        step();
        chk("sb_empty", sb.size() > 0 ? 16'd1 : 16'd0, 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_byte_pair_packer
`default_nettype wire
